// File: rtl/premuat_pipe.sv
// -----------------------------------------------------------------------------
// premuat_pipe
//
// Purpose:
//   One-stage lane permutation pipeline. Each accepted beat carries NMAX
//   signed lanes of WIDTH bits. Within the first N lanes (N = 4<<i_size,
//   clamped to NMAX) the lanes are either interleaved (forward) or
//   de-interleaved (inverse):
//     forward : o[2k] = i[k],  o[2k+1]   = i[k+N/2]
//     inverse : o[k]  = i[2k], o[k+N/2]  = i[2k+1]
//   Lanes N..NMAX-1 pass unchanged, and with enable=0 every lane passes
//   unchanged. Lane values are only moved, never modified.
//   The permutation is applied on the input side. The result is then
//   registered, so a beat accepted at one edge is presented after that
//   edge with o_valid=1.
//
// Configuration:
//   PREMUAT_SKID_EN undefined (default): there is a single output register.
//     The ready output is combinational: o_rdy = ~o_valid | i_rdy.
//   PREMUAT_SKID_EN defined: a second (skid) entry holds a beat that arrives
//     while the output register is stalled. o_rdy comes straight from a
//     flop and means "skid entry empty". Up to two beats are held.
//
// Parameters:
//   WIDTH  lane width in bits (signed samples)
//   NMAX   lane count, a power of two in 4..32
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; clears all state
//   enable   1 = permute, 0 = pass through (sampled with each beat)
//   inverse  0 = forward interleave, 1 = inverse de-interleave
//   i_size   transform size code: 0=4, 1=8, 2=16, 3=32 points
//   i_valid  upstream beat valid
//   o_rdy    block can accept a beat
//   i_data   input lanes, lane k at [k*WIDTH +: WIDTH]
//   o_valid  output beat valid
//   i_rdy    downstream accepts the beat
//   o_data   permuted lanes, same packing as i_data
// -----------------------------------------------------------------------------
module premuat_pipe #(
   parameter int WIDTH = 16,
   parameter int NMAX  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  inverse,
   input  logic [1:0]            i_size,
   input  logic                  i_valid,
   output logic                  o_rdy,
   input  logic [NMAX*WIDTH-1:0] i_data,
   output logic                  o_valid,
   input  logic                  i_rdy,
   output logic [NMAX*WIDTH-1:0] o_data
);

   // ------------------------------------------------------------------
   // Input-side permutation. It is purely combinational and depends only
   // on the controls presented alongside the beat. Because of this, the
   // controls take effect for exactly the beat they accompany.
   // ------------------------------------------------------------------
   logic [NMAX*WIDTH-1:0] perm_data;
   int                    n_eff;
   int                    half_n;
   int                    src_lane;

   // NOTE: every variable written here gets a value before any branch;
   // a path that left one unassigned would infer a latch.
   always_comb begin
      perm_data = '0;
      src_lane  = 0;

      case (i_size)
         2'd0:    n_eff = 4;
         2'd1:    n_eff = 8;
         2'd2:    n_eff = 16;
         default: n_eff = 32;
      endcase
      if (n_eff > NMAX) begin
         n_eff = NMAX;
      end
      half_n = n_eff / 2;

      for (int j = 0; j < NMAX; j++) begin
         src_lane = j;
         if (enable && (j < n_eff)) begin
            if (!inverse) begin
               // Even outputs take the lower half and odd outputs take the upper half.
               src_lane = (j % 2 == 0) ? (j / 2) : (j / 2 + half_n);
            end else begin
               // The first half collects even inputs and the second half collects odd inputs.
               src_lane = (j < half_n) ? (2 * j) : (2 * (j - half_n) + 1);
            end
         end
         perm_data[j*WIDTH +: WIDTH] = i_data[src_lane*WIDTH +: WIDTH];
      end
   end

   logic accept;
   logic emit;

   assign emit = o_valid & i_rdy;

`ifdef PREMUAT_SKID_EN
   // ------------------------------------------------------------------
   // Output register plus skid entry. skid_empty is the registered ready.
   // The skid entry only fills when a beat is accepted while the output
   // register is full and stalled. In that state, ready drops for the
   // following cycle, so at most two beats are ever held.
   // ------------------------------------------------------------------
   logic                  skid_empty;
   logic [NMAX*WIDTH-1:0] skid_data;

   assign o_rdy  = skid_empty;
   assign accept = i_valid & skid_empty;

   // NOTE: the data registers are reset as well as the valid flags, so
   // o_data reads zero during and right after reset, not stale lanes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid    <= 1'b0;
         o_data     <= '0;
         skid_empty <= 1'b1;
         skid_data  <= '0;
      end else if (!skid_empty) begin
         // Two beats are held. Ready is low, so nothing new can arrive.
         // The skid beat moves forward once the output beat leaves.
         if (i_rdy) begin
            o_data     <= skid_data;
            skid_empty <= 1'b1;
         end
      end else if (accept) begin
         if (!o_valid || i_rdy) begin
            // The output register is free or draining this edge, so the new beat replaces it.
            o_data  <= perm_data;
            o_valid <= 1'b1;
         end else begin
            skid_data  <= perm_data;
            skid_empty <= 1'b0;
         end
      end else if (emit) begin
         o_valid <= 1'b0;
      end
   end
`else
   // ------------------------------------------------------------------
   // Single output register. The block accepts a beat whenever that
   // register is empty or draining on the same edge.
   // ------------------------------------------------------------------
   assign o_rdy  = ~o_valid | i_rdy;
   assign accept = i_valid & o_rdy;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (accept) begin
         o_data  <= perm_data;
         o_valid <= 1'b1;
      end else if (emit) begin
         o_valid <= 1'b0;
      end
   end
`endif

endmodule
